uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
//
// Byte FIFO in front of a simple UART transmitter core. Bytes pushed on the
// write side are queued in a circular buffer and handed to the core one at a
// time. The core is started with a one-cycle tx_send pulse. Its transmit-done
// flag is acknowledged with a one-cycle tx_flag_clr pulse.
//
// Ports
//   clk          single clock for all logic
//   n_rst        asynchronous, active-low reset
//   wr_en        push request, sampled on rising clk
//   wr_data      byte to push
//   ovf_clr      clears the sticky overflow flag
//   tx_flag      core transmit-done flag (level, held until cleared)
//   tx_data      byte presented to the core (registered)
//   tx_send      start request to the core (registered one-cycle pulse)
//   tx_flag_clr  clear request for the core tx_flag (registered one-cycle pulse)
//   full         FIFO holds DEPTH entries
//   empty        FIFO holds no entries
//   count        current FIFO occupancy
//   busy         feeder is not idle
//   overflow     sticky: a push was dropped because the FIFO was full
//
// DEPTH must be a power of two (minimum 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      ovf_clr,
    input  logic                      tx_flag,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_send,
    output logic                      tx_flag_clr,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      busy,
    output logic                      overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_DONE,
        CLEAR,
        GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_send_q, tx_send_d;
    logic                    tx_flag_clr_q, tx_flag_clr_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    full_w;
    logic                    empty_w;
    logic                    pop;
    logic                    push_ok;
    logic                    push_drop;

    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);

    // Feeder state machine: next state, pop request and tx_data load.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_w) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = SEND;
                end
            end
            SEND:      state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (tx_flag) begin
                    state_d = CLEAR;
                end
            end
            CLEAR:     state_d = GAP;
            GAP:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // The start pulse is launched from SEND and reaches the port one cycle
    // later, so tx_data has been stable for a full cycle before the core sees
    // the start. The flag clear is issued while in CLEAR; GAP then gives the
    // core flag register a cycle to drop before IDLE can pop again.
    always_comb begin
        tx_send_d     = (state_q == SEND);
        tx_flag_clr_d = (state_d == CLEAR);
    end

    // FIFO bookkeeping. A pop frees a slot in the same cycle, so a push into
    // a full FIFO is still accepted when the feeder is popping.
    always_comb begin
        push_ok   = wr_en && (!full_w || pop);
        push_drop = wr_en && full_w && !pop;

        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop     ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A dropped push wins over a simultaneous clear.
        if (push_drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            tx_data_q     <= '0;
            tx_send_q     <= 1'b0;
            tx_flag_clr_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            tx_data_q     <= tx_data_d;
            tx_send_q     <= tx_send_d;
            tx_flag_clr_q <= tx_flag_clr_d;
        end
    end

    // Storage is not reset: entries are unreachable while empty is high.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_send     = tx_send_q;
    assign tx_flag_clr = tx_flag_clr_q;
    assign full        = full_w;
    assign empty       = empty_w;
    assign count       = count_q;
    assign busy        = (state_q != IDLE);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder
//
// Self-checking bench for uart_tx_feeder. A transaction-level reference model
// (a byte queue plus edge-number bookkeeping of when the feeder may pop, when
// it starts the core and when it acknowledges the core) predicts every output
// after every clock edge. A small UART core emulation raises tx_flag some
// cycles after each start pulse and drops it on tx_flag_clr.
// ---------------------------------------------------------------------------
module tb_uart_tx_feeder;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int VW    = CW + 6 + DW;
    localparam logic [VW-1:0] RST_VEC = {CW'(0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DW'(0)};

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          ovf_clr = 1'b0;
    logic          tx_flag = 1'b0;
    logic [DW-1:0] tx_data;
    logic          tx_send;
    logic          tx_flag_clr;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          busy;
    logic          overflow;
    logic [VW-1:0] ovec;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            e = 0;          // number of the most recent clock edge
    logic [DW-1:0] mq[$];          // bytes waiting in the FIFO
    bit            in_tx;          // a byte has been popped and not yet acknowledged
    int            pop_edge;       // edge at which the current byte was popped
    int            done_edge;      // edge at which tx_flag was last accepted
    logic [DW-1:0] m_data;         // last popped byte
    bit            m_ovf;

    // UART core emulation and observed traffic
    bit            core_auto;
    int            core_delay;
    int            core_cnt;
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_b[$];

    uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .ovf_clr    (ovf_clr),
        .tx_flag    (tx_flag),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_flag_clr(tx_flag_clr),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    assign ovec = {count, full, empty, overflow, busy, tx_send, tx_flag_clr, tx_data};

    // Feeder is busy while a byte is outstanding and for the two cycles
    // (clear, gap) after the done flag is accepted.
    function automatic bit m_busy();
        return in_tx || (e < done_edge + 2);
    endfunction

    function automatic logic [VW-1:0] mvec();
        logic [CW-1:0] c;
        c = CW'(mq.size());
        return {c, c == CW'(DEPTH), c == '0, m_ovf, m_busy(),
                in_tx && (e == pop_edge + 1), e == done_edge, m_data};
    endfunction

    task automatic model_reset();
        mq.delete();
        in_tx     = 1'b0;
        pop_edge  = -100;
        done_edge = -100;
        m_data    = '0;
        m_ovf     = 1'b0;
        tx_flag   = 1'b0;
        core_cnt  = 0;
    endtask

    // Apply the rules for one rising edge using the inputs the DUT sampled.
    task automatic model_edge();
        bit pop;
        bit done;
        bit drop;
        e++;
        done = in_tx && (e >= pop_edge + 2) && (tx_flag == 1'b1);
        pop  = !in_tx && (e >= done_edge + 3) && (mq.size() > 0);
        drop = (wr_en == 1'b1) && (mq.size() == DEPTH) && !pop;
        if (pop) begin
            m_data   = mq.pop_front();
            in_tx    = 1'b1;
            pop_edge = e;
        end
        if (done) begin
            in_tx     = 1'b0;
            done_edge = e;
        end
        if (wr_en == 1'b1 && !drop) mq.push_back(wr_data);
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr == 1'b1) m_ovf = 1'b0;
    endtask

    // One clock: model follows the edge, outputs are observed on the falling
    // edge, and the core emulation updates tx_flag for the next edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (tx_send === 1'b1) got.push_back(tx_data);
        if (core_auto) begin
            if (tx_flag_clr === 1'b1) tx_flag = 1'b0;
            if (tx_send === 1'b1) begin
                core_cnt = core_delay;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) tx_flag = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ovec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_values got %h exp %h", ovec, RST_VEC);
        end
        n_rst = 1'b1;
        step();
        checks++;
        if (ovec !== mvec()) begin
            errors++;
            $display("FAIL reset_idle got %h exp %h", ovec, mvec());
        end
    endtask

    task automatic test_single();
        int send_at = -1;
        int clr_at  = -1;
        int idle_at = -1;
        core_auto = 1'b1;
        core_delay = 100;
        got.delete();
        wr_en = 1'b1;
        wr_data = 8'h41;
        for (int i = 0; i < 120; i++) begin
            step();
            wr_en = 1'b0;
            checks++;
            if (ovec !== mvec()) begin
                errors++;
                $display("FAIL single cyc %0d got %h exp %h", i, ovec, mvec());
            end
            if (i == 0) begin
                checks++;
                if (count !== CW'(1)) begin
                    errors++;
                    $display("FAIL single_first_push count %0d exp 1", count);
                end
            end
            if (tx_send === 1'b1 && send_at < 0) send_at = i;
            if (tx_flag_clr === 1'b1 && clr_at < 0) clr_at = i;
            if (clr_at >= 0 && idle_at < 0 && busy === 1'b0) idle_at = i;
        end
        checks++;
        if (send_at != 2) begin
            errors++;
            $display("FAIL single_latency send after edge +%0d exp +2", send_at);
        end
        checks++;
        if (got.size() != 1 || got[0] !== 8'h41) begin
            errors++;
            $display("FAIL single_byte sent %0d bytes exp 1 byte 41", got.size());
        end
        checks++;
        if (clr_at < 0 || idle_at - clr_at != 2) begin
            errors++;
            $display("FAIL single_idle busy low %0d cycles after clr exp 2", idle_at - clr_at);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 600 && (m_busy() || mq.size() != 0); i++) begin
            step();
            checks++;
            if (ovec !== mvec()) begin
                errors++;
                $display("FAIL %s_drain cyc %0d got %h exp %h", name, i, ovec, mvec());
            end
        end
    endtask

    task automatic test_burst();
        bit ok;
        core_auto = 1'b1;
        core_delay = int'($urandom_range(1, 6));
        got.delete();
        exp_b.delete();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_data = DW'(8'h10 + i);
            exp_b.push_back(wr_data);
            step();
            checks++;
            if (ovec !== mvec()) begin
                errors++;
                $display("FAIL burst cyc %0d got %h exp %h", i, ovec, mvec());
            end
        end
        wr_en = 1'b0;
        // The first byte is popped one edge after it is pushed, so eight
        // back-to-back pushes never fill the FIFO.
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL burst_full got %b exp 0", full);
        end
        drain("burst");
        checks++;
        if (busy !== 1'b0 || empty !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL burst_end busy %b empty %b count %0d exp 0 1 0", busy, empty, count);
        end
        ok = (got.size() == exp_b.size());
        foreach (exp_b[i]) if (ok && got[i] !== exp_b[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL burst_order sent %0d bytes exp %0d in order", got.size(), exp_b.size());
        end
    endtask

    task automatic fill_while_waiting(input logic [DW-1:0] base, input string name);
        core_auto = 1'b0;
        got.delete();
        exp_b.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr_en = 1'b1;
            wr_data = base + DW'(i);
            exp_b.push_back(wr_data);
            step();
            checks++;
            if (ovec !== mvec()) begin
                errors++;
                $display("FAIL %s_fill cyc %0d got %h exp %h", name, i, ovec, mvec());
            end
        end
        wr_en = 1'b0;
        checks++;
        if (full !== 1'b1 || count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL %s_full full %b count %0d exp 1 %0d", name, full, count, DEPTH);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        fill_while_waiting(8'h60, "ovf");
        wr_en = 1'b1;
        wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL ovf_set overflow %b count %0d exp 1 %0d", overflow, count, DEPTH);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear overflow %b exp 0", overflow);
        end
        wr_en = 1'b1;
        wr_data = 8'hAB;
        ovf_clr = 1'b1;
        step();
        wr_en = 1'b0;
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_priority overflow %b exp 1", overflow);
        end
        checks++;
        if (ovec !== mvec()) begin
            errors++;
            $display("FAIL ovf_state got %h exp %h", ovec, mvec());
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        tx_flag = 1'b1;
        core_auto = 1'b1;
        core_delay = int'($urandom_range(1, 5));
        drain("ovf");
        ok = (got.size() == exp_b.size());
        foreach (exp_b[i]) if (ok && got[i] !== exp_b[i]) ok = 1'b0;
        checks++;
        if (!ok || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_order sent %0d bytes exp %0d, overflow %b exp 0", got.size(), exp_b.size(), overflow);
        end
    endtask

    task automatic test_full_pushpop();
        bit ok;
        bit hit = 1'b0;
        fill_while_waiting(8'h80, "fpp");
        tx_flag = 1'b1;
        core_auto = 1'b1;
        core_delay = 3;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (!in_tx && (e + 1 >= done_edge + 3) && mq.size() > 0) begin
                wr_en = 1'b1;
                wr_data = 8'h55;
                hit = 1'b1;
            end
            step();
            wr_en = 1'b0;
            checks++;
            if (ovec !== mvec()) begin
                errors++;
                $display("FAIL fpp cyc %0d got %h exp %h", i, ovec, mvec());
            end
        end
        checks++;
        if (!hit || count !== CW'(DEPTH) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_count count %0d overflow %b exp %0d 0", count, overflow, DEPTH);
        end
        exp_b.push_back(8'h55);
        drain("fpp");
        ok = (got.size() == exp_b.size());
        foreach (exp_b[i]) if (ok && got[i] !== exp_b[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fpp_order sent %0d bytes exp %0d, 55 last", got.size(), exp_b.size());
        end
    endtask

    task automatic test_flag_ignored();
        core_auto = 1'b0;
        tx_flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (tx_flag_clr !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL flag_idle cyc %0d clr %b busy %b exp 0 0", i, tx_flag_clr, busy);
            end
        end
        tx_flag = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        core_auto = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = DW'(8'hC0 + i);
            step();
        end
        wr_en = 1'b0;
        step();
        checks++;
        if (count !== CW'(3) || busy !== 1'b1 || ovec !== mvec()) begin
            errors++;
            $display("FAIL rstmid_pre got %h exp %h", ovec, mvec());
        end
        #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if (ovec !== RST_VEC) begin
            errors++;
            $display("FAIL rstmid_async got %h exp %h", ovec, RST_VEC);
        end
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        got.delete();
        core_auto = 1'b1;
        core_delay = int'($urandom_range(1, 5));
        wr_en = 1'b1;
        wr_data = 8'h33;
        step();
        wr_en = 1'b0;
        checks++;
        if (ovec !== mvec()) begin
            errors++;
            $display("FAIL rstmid_push got %h exp %h", ovec, mvec());
        end
        drain("rstmid");
        checks++;
        if (got.size() != 1 || got[0] !== 8'h33) begin
            errors++;
            $display("FAIL rstmid_byte sent %0d bytes exp 1 byte 33", got.size());
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int n = 0;
        core_auto = 1'b1;
        core_delay = int'($urandom_range(1, 4));
        got.delete();
        exp_b.delete();
        for (int i = 0; i < 2000 && (n < 20 || m_busy() || mq.size() != 0); i++) begin
            wr_en = 1'b0;
            if (n < 20 && mq.size() < 3 && $urandom_range(0, 2) != 0) begin
                wr_en = 1'b1;
                wr_data = DW'($urandom);
                exp_b.push_back(wr_data);
                n++;
            end
            step();
            checks++;
            if (ovec !== mvec()) begin
                errors++;
                $display("FAIL wrap cyc %0d got %h exp %h", i, ovec, mvec());
            end
            checks++;
            if ($isunknown(count) || count > CW'(3)) begin
                errors++;
                $display("FAIL wrap_occupancy count %0d exp at most 3", count);
            end
        end
        wr_en = 1'b0;
        ok = (got.size() == exp_b.size()) && (n == 20);
        foreach (exp_b[i]) if (ok && got[i] !== exp_b[i]) ok = 1'b0;
        checks++;
        if (!ok || overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_order sent %0d bytes exp 20, overflow %b exp 0", got.size(), overflow);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pushpop();
        test_flag_ignored();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
